// File: rtl/conv_engine.sv
// conv_engine: loads a 4x4 image, then computes four 3x3 stride-1 and four 2x2 stride-2 convolutions with one MAC.
// Latency: done rises 52 cycles after the edge that accepts the 16th pixel (36 MAC9 + 16 MAC4 cycles).
// Backpressure: pix_ready is high only in LOAD; gaps in pix_valid stall the load, start is ignored while busy.
// Ports: clk/resetn (sync, active-low); start + k9/k4 kernels; pix_valid/pix_ready/pix_data pixel stream;
//        c9_* / c4_* saturated results; busy (LOAD/MAC9/MAC4); done (results valid and held).
module conv_engine #(
  parameter int PIX_W = 4,
  parameter int W_W   = 2,
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [9*W_W-1:0]   k9,
  input  logic [4*W_W-1:0]   k4,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               pix_ready,
  output logic [OUT_W-1:0]   c9_11,
  output logic [OUT_W-1:0]   c9_12,
  output logic [OUT_W-1:0]   c9_21,
  output logic [OUT_W-1:0]   c9_22,
  output logic [OUT_W-1:0]   c4_11,
  output logic [OUT_W-1:0]   c4_12,
  output logic [OUT_W-1:0]   c4_21,
  output logic [OUT_W-1:0]   c4_22,
  output logic               busy,
  output logic               done
);

  localparam int PROD_W = PIX_W + W_W;
  // Nine products need four extra bits; never narrower than 11 bits.
  localparam int ACC_W  = (PROD_W + 4 > 11) ? PROD_W + 4 : 11;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC9, S_MAC4, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W_W-1:0]     k9_q [9];
  logic [W_W-1:0]     k4_q [4];
  logic [PIX_W-1:0]   pix_buf [16];
  logic [3:0]         pix_cnt_q;
  logic [1:0]         res_q;      // which of the four results is being accumulated
  logic [1:0]         ki_q, kj_q; // kernel row/col of the current term
  logic [ACC_W-1:0]   acc_q;
  logic [OUT_W-1:0]   c9_q [4];
  logic [OUT_W-1:0]   c4_q [4];

  logic               job_start, beat_acc, mac_en, last_term;
  logic [1:0]         row, col, k_last;
  logic [3:0]         idx9;
  logic [W_W-1:0]     w_sel;
  logic [PIX_W-1:0]   p_sel;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   acc_sum;
  logic [OUT_W-1:0]   sat_val;

  always_comb begin
    state_d   = state_q;
    job_start = 1'b0;
    beat_acc  = 1'b0;
    mac_en    = 1'b0;
    row       = '0;
    col       = '0;
    k_last    = 2'd1;
    idx9      = '0;
    w_sel     = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          job_start = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pix_valid) begin
          beat_acc = 1'b1;
          if (pix_cnt_q == 4'd15) state_d = S_MAC9;
        end
      end
      S_MAC9: begin
        // Result (r,c) covers pixel rows r..r+2, cols c..c+2 (0-based origin).
        mac_en = 1'b1;
        k_last = 2'd2;
        row    = {1'b0, res_q[1]} + ki_q;
        col    = {1'b0, res_q[0]} + kj_q;
        idx9   = {2'b00, ki_q} * 4'd3 + {2'b00, kj_q};
        w_sel  = k9_q[idx9];
      end
      S_MAC4: begin
        // Stride 2: result (r,c) starts at pixel (2r, 2c).
        mac_en = 1'b1;
        k_last = 2'd1;
        row    = {res_q[1], 1'b0} + ki_q;
        col    = {res_q[0], 1'b0} + kj_q;
        w_sel  = k4_q[{ki_q[0], kj_q[0]}];
      end
      default: state_d = S_IDLE;
    endcase

    last_term = mac_en && (ki_q == k_last) && (kj_q == k_last);
    if (last_term && res_q == 2'd3) begin
      state_d = (state_q == S_MAC9) ? S_MAC4 : S_DONE;
    end
  end

  assign p_sel   = pix_buf[{row, col}];
  assign prod    = PROD_W'(w_sel) * PROD_W'(p_sel);
  assign acc_sum = acc_q + ACC_W'(prod);
  assign sat_val = (|(acc_sum >> OUT_W)) ? '1 : OUT_W'(acc_sum);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      res_q     <= '0;
      ki_q      <= '0;
      kj_q      <= '0;
      acc_q     <= '0;
      for (int i = 0; i < 9; i++) k9_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        k4_q[i] <= '0;
        c9_q[i] <= '0;
        c4_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (job_start) begin
        for (int i = 0; i < 9; i++) k9_q[i] <= k9[i*W_W +: W_W];
        for (int i = 0; i < 4; i++) begin
          k4_q[i] <= k4[i*W_W +: W_W];
          c9_q[i] <= '0;
          c4_q[i] <= '0;
        end
        pix_cnt_q <= '0;
        res_q     <= '0;
        ki_q      <= '0;
        kj_q      <= '0;
        acc_q     <= '0;
      end
      if (beat_acc) pix_cnt_q <= pix_cnt_q + 4'd1;
      if (mac_en) begin
        if (last_term) begin
          // Final term lands straight in the result; accumulator restarts.
          if (state_q == S_MAC9) c9_q[res_q] <= sat_val;
          else                   c4_q[res_q] <= sat_val;
          acc_q <= '0;
          res_q <= res_q + 2'd1;
          ki_q  <= '0;
          kj_q  <= '0;
        end else begin
          acc_q <= acc_sum;
          if (kj_q == k_last) begin
            kj_q <= '0;
            ki_q <= ki_q + 2'd1;
          end else begin
            kj_q <= kj_q + 2'd1;
          end
        end
      end
    end
  end

  // Image buffer carries no reset: its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (beat_acc) pix_buf[pix_cnt_q] <= pix_data;
  end

  assign pix_ready = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_MAC9) || (state_q == S_MAC4);
  assign done      = (state_q == S_DONE);

  assign c9_11 = c9_q[0];
  assign c9_12 = c9_q[1];
  assign c9_21 = c9_q[2];
  assign c9_22 = c9_q[3];
  assign c4_11 = c4_q[0];
  assign c4_12 = c4_q[1];
  assign c4_21 = c4_q[2];
  assign c4_22 = c4_q[3];

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: random and directed jobs for conv_engine, checked every cycle against a behavioural model.
// Latency: model publishes each result on the cycle its last MAC term is due; done 52 cycles after the 16th beat.
// Backpressure: pixel beats are sent with random gaps; start pulses during a job must be ignored.
module tb_conv_engine;
  localparam int PIX_W = 4;
  localparam int W_W   = 2;
  localparam int OUT_W = 8;
  localparam int SATV  = (1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [9*W_W-1:0]  k9 = '0;
  logic [4*W_W-1:0]  k4 = '0;
  logic              pix_valid = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_ready, busy, done;
  logic [OUT_W-1:0]  c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22;

  conv_engine #(.PIX_W(PIX_W), .W_W(W_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .k9(k9), .k4(k4),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .c9_11(c9_11), .c9_12(c9_12), .c9_21(c9_21), .c9_22(c9_22),
    .c4_11(c4_11), .c4_12(c4_12), .c4_21(c4_21), .c4_22(c4_22),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 loading, 2 computing, 3 done
  bit m_valid = 1'b0;
  int m_phase = 0;
  int m_beats = 0;
  int m_cyc   = 0;
  int mp [16];
  int mw9 [9];
  int mw4 [4];
  int f9 [4];
  int f4 [4];
  int e9 [4];
  int e4 [4];

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic compute_finals();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        int s9, s4;
        s9 = 0;
        s4 = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s9 += mw9[i*3+j] * mp[(r+i)*4 + (c+j)];
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            s4 += mw4[i*2+j] * mp[(2*r+i)*4 + (2*c+j)];
        f9[r*2+c] = sat(s9);
        f4[r*2+c] = sat(s4);
      end
    end
  endtask

  task automatic clear_expected();
    for (int i = 0; i < 4; i++) begin
      e9[i] = 0;
      e4[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      m_valid = 1'b1;
      m_phase = 0;
      clear_expected();
    end else if (m_valid) begin
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1;
          m_beats = 0;
          for (int i = 0; i < 9; i++) mw9[i] = int'(k9[i*W_W +: W_W]);
          for (int i = 0; i < 4; i++) mw4[i] = int'(k4[i*W_W +: W_W]);
          clear_expected();
        end
        1: if (pix_valid) begin
          mp[m_beats] = int'(pix_data);
          m_beats++;
          if (m_beats == 16) begin
            m_phase = 2;
            m_cyc   = 0;
            compute_finals();
          end
        end
        2: begin
          // Nine cycles per 3x3 result, then four cycles per 2x2 result.
          m_cyc++;
          if (m_cyc <= 36 && m_cyc % 9 == 0) e9[m_cyc/9 - 1] = f9[m_cyc/9 - 1];
          if (m_cyc > 36 && (m_cyc - 36) % 4 == 0) e4[(m_cyc-36)/4 - 1] = f4[(m_cyc-36)/4 - 1];
          if (m_cyc == 52) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pix_ready", int'(pix_ready), int'(m_phase == 1));
      chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
      chk("done", int'(done), int'(m_phase == 3));
      chk("c9_11", int'(c9_11), e9[0]);
      chk("c9_12", int'(c9_12), e9[1]);
      chk("c9_21", int'(c9_21), e9[2]);
      chk("c9_22", int'(c9_22), e9[3]);
      chk("c4_11", int'(c4_11), e4[0]);
      chk("c4_12", int'(c4_12), e4[1]);
      chk("c4_21", int'(c4_21), e4[2]);
      chk("c4_22", int'(c4_22), e4[3]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns the number of edges from the 16th accepted beat to done (999 if never, -1 if reset).
  task automatic run_job(input int pix [16], input logic [9*W_W-1:0] kk9, input logic [4*W_W-1:0] kk4,
                         input int gap_pct, input bit start_in_mac, input int reset_at, output int lat);
    int idx, guard;
    k9    = kk9;
    k4    = kk4;
    start = 1'b1;
    tick();
    start = 1'b0;
    k9    = (9*W_W)'($urandom);
    k4    = (4*W_W)'($urandom);
    idx   = 0;
    guard = 0;
    while (idx < 16 && guard < 2000) begin
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_data  = pix_valid ? PIX_W'(pix[idx]) : PIX_W'($urandom);
      start     = (gap_pct > 0) && ($urandom_range(3) == 0);
      tick();
      guard++;
      if (pix_valid) idx++;
    end
    start = 1'b0;
    if (idx < 16) chk("load_timeout", idx, 16);
    lat = 999;
    for (int n = 1; n <= 200; n++) begin
      pix_valid = 1'($urandom_range(1));
      pix_data  = PIX_W'($urandom);
      start     = start_in_mac && (n == 5);
      resetn    = !(reset_at == n);
      @(posedge clk);
      #1;
      if (reset_at > 0 && n > reset_at) begin
        lat = -1;
        break;
      end
      if (done) begin
        lat = n;
        break;
      end
      #1;
    end
    #1;
    pix_valid = 1'b0;
    start     = 1'b0;
    resetn    = 1'b1;
    tick();
  endtask

  int pa [16];
  int lat;
  logic [9*W_W-1:0] rk9;
  logic [4*W_W-1:0] rk4;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_done", int'(done), 0);
    chk("reset_c9_11", int'(c9_11), 0);
    resetn = 1'b1;
    repeat (3) tick();

    // Saturation: all pixels 15, all weights 3.
    for (int i = 0; i < 16; i++) pa[i] = 15;
    run_job(pa, '1, '1, 0, 1'b0, 0, lat);
    chk("latency_sat", lat, 52);
    chk("model_f9_sat", f9[0], 255);
    chk("model_f4_sat", f4[3], 180);
    chk("lit_c9_22", int'(c9_22), 255);
    chk("lit_c4_11", int'(c4_11), 180);

    // Identity-like kernels on p(r,c) = 4r+c.
    for (int i = 0; i < 16; i++) pa[i] = i;
    run_job(pa, 18'h00100, 8'h01, 0, 1'b0, 0, lat);
    chk("latency_id", lat, 52);
    chk("lit_c9_11", int'(c9_11), 5);
    chk("lit_c9_12", int'(c9_12), 6);
    chk("lit_c9_21", int'(c9_21), 9);
    chk("lit_c9_22b", int'(c9_22), 10);
    chk("lit_c4_11b", int'(c4_11), 0);
    chk("lit_c4_12", int'(c4_12), 2);
    chk("lit_c4_21", int'(c4_21), 8);
    chk("lit_c4_22", int'(c4_22), 10);
    chk("model_f9_id", f9[3], 10);

    // Zero weights.
    for (int i = 0; i < 16; i++) pa[i] = int'($urandom_range(15));
    run_job(pa, '0, '0, 0, 1'b0, 0, lat);
    chk("latency_zero", lat, 52);
    chk("lit_zero_c9_12", int'(c9_12), 0);
    chk("lit_zero_c4_21", int'(c4_21), 0);

    // Same job gap-free, then with gaps and a start pulse during MAC9.
    for (int i = 0; i < 16; i++) pa[i] = int'($urandom_range(15));
    rk9 = (9*W_W)'($urandom);
    rk4 = (4*W_W)'($urandom);
    run_job(pa, rk9, rk4, 0, 1'b0, 0, lat);
    chk("latency_nogap", lat, 52);
    run_job(pa, rk9, rk4, 40, 1'b1, 0, lat);
    chk("latency_gap", lat, 52);

    // Reset during MAC9, then a fresh full job.
    run_job(pa, rk9, rk4, 20, 1'b0, 10, lat);
    chk("reset_abort", lat, -1);
    chk("reset_c9_after", int'(c9_11), 0);
    chk("reset_busy_after", int'(busy), 0);
    run_job(pa, rk9, rk4, 20, 1'b0, 0, lat);
    chk("latency_after_reset", lat, 52);

    // Random jobs with random gaps.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) pa[i] = int'($urandom_range(15));
      run_job(pa, (9*W_W)'($urandom), (4*W_W)'($urandom), int'($urandom_range(60)), 1'($urandom_range(1)), 0, lat);
      chk("latency_rand", lat, 52);
      repeat (int'($urandom_range(3))) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter PIX_W, default 4, pixel width in bits (unsigned).
REQ-002 Parameter W_W, default 2, kernel weight width in bits (unsigned).
REQ-003 Parameter OUT_W, default 8, result width; results saturate to 2^OUT_W-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begin a job; honoured only in IDLE or DONE.
REQ-007 k9  input  9*W_W  3x3 kernel, raster order, w(0,0) in [W_W-1:0], w(2,2) in the top slice.
REQ-008 k4  input  4*W_W  2x2 kernel, raster order, same packing as k9.
REQ-009 pix_valid  input  1  pixel beat valid.
REQ-010 pix_data  input  PIX_W  pixel value; a 4x4 image is sent in raster order, p(r,c) is beat r*4+c.
REQ-011 pix_ready  output  1  high only in LOAD; beat accepted when pix_valid and pix_ready are both high.
REQ-012 c9_11, c9_12, c9_21, c9_22  output  OUT_W each  3x3-kernel stride-1 results, row/col order.
REQ-013 c4_11, c4_12, c4_21, c4_22  output  OUT_W each  2x2-kernel stride-2 results.
REQ-014 busy  output  1  high in LOAD, MAC9, MAC4.
REQ-015 done  output  1  high in DONE; all eight results valid and stable.

Function
REQ-016 FSM states: IDLE, LOAD, MAC9, MAC4, DONE.
REQ-017 IDLE/DONE + start -> LOAD; k9 and k4 latched; all eight results cleared to 0; pixel counter cleared.
REQ-018 In LOAD, each accepted beat writes the internal 16-entry buffer; gaps in pix_valid stall without error.
REQ-019 LOAD -> MAC9 on the edge that accepts the 16th beat.
REQ-020 MAC9 runs 36 cycles, one product w*p added to an accumulator per cycle; outputs in order c9_11, c9_12, c9_21, c9_22, each 9 terms in kernel raster order.
REQ-021 c9_rc (r,c in 1..2) = sum over i,j in 0..2 of w9(i,j)*p(r-1+i, c-1+j).
REQ-022 MAC4 runs 16 cycles; outputs in order c4_11..c4_22, 4 terms each.
REQ-023 c4_rc = sum over i,j in 0..1 of w4(i,j)*p(2(r-1)+i, 2(c-1)+j).
REQ-024 Accumulator is at least 11 bits wide (max 9*15*3=405) and never wraps.
REQ-025 Each result is written on the edge that adds its final term: min(acc, 2^OUT_W-1). The accumulator then clears for the next result.
REQ-026 MAC4 -> DONE after 16 cycles; done rises exactly 52 cycles after the edge accepting the 16th beat.
REQ-027 In DONE, results hold until the next start or reset.
REQ-028 start in LOAD/MAC9/MAC4 is ignored; pix_valid outside LOAD is ignored.
REQ-029 start and the 16th beat never coincide in a way that matters, because start is only sampled in IDLE/DONE.

Reset
REQ-030 resetn low at a rising edge -> next state IDLE.
REQ-031 On reset, all eight results, busy, done and pix_ready are 0; accumulator and counters are 0.
REQ-032 Reset mid-operation (any state) aborts the job with no partial results retained; buffer contents are don't-care.

Verification
REQ-033 All pixels 15, all weights 3 -> c9_* = 255 (405 saturated); c4_* = 180.
REQ-034 p(r,c) = 4r+c, k9 only w(1,1)=1, k4 only w(0,0)=1 -> c9 = 5,6,9,10; c4 = 0,2,8,10.
REQ-035 Count cycles from the 16th accepted beat -> done high on the 52nd edge; busy low in the same cycle.
REQ-036 Random pix_valid gaps plus a start pulse during MAC9 -> results match the gap-free run; the start pulse has no effect.
REQ-037 resetn low during MAC9 -> next cycle all outputs 0; then a fresh start with full stimulus completes correctly.
REQ-038 All weights 0, arbitrary pixels -> all eight results 0, done asserted on schedule.
